// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the two-port memory arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_ren;
    logic [1:0]        req_wen;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_store0;
    logic [DATA_W-1:0] req_store1;
    logic [1:0]        req_wait;
    logic [DATA_W-1:0] req_load;
    logic [1:0]        req_err;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  req_ren, req_wen, req_addr0, req_addr1, req_store0, req_store1,
        input  ramload, ramstate,
        output req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output req_ren, req_wen, req_addr0, req_addr1, req_store0, req_store1,
        output ramload, ramstate,
        input  req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between two requesters.
// A grant ends on RAM ACCESS, on requester abort, or when the stall timeout expires.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic           CLK,
    input  logic           RST,
    mem_arbiter_if.slave   bus
);
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         act;
    logic               n;
    logic [1:0]         wait_c, err_c;
    logic [DATA_W-1:0]  load_c, store_c;
    logic [ADDR_W-1:0]  addr_c;
    logic               ren_c, wen_c;

    assign act = bus.req_ren | bus.req_wen;
    assign n   = (state_q == GNT1);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        wait_c  = act;
        err_c   = 2'b00;
        load_c  = '0;
        addr_c  = '0;
        store_c = '0;
        ren_c   = 1'b0;
        wen_c   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                case (act)
                    2'b01:   state_d = GNT0;
                    2'b10:   state_d = GNT1;
                    2'b11:   state_d = rr_q ? GNT1 : GNT0;
                    default: state_d = IDLE;
                endcase
            end
            GNT0, GNT1: begin
                addr_c  = n ? bus.req_addr1  : bus.req_addr0;
                store_c = n ? bus.req_store1 : bus.req_store0;
                if (!act[n]) begin
                    // Requester gave up: release quietly, priority untouched
                    state_d = IDLE;
                end else begin
                    wen_c = bus.req_wen[n];
                    ren_c = bus.req_ren[n] & ~bus.req_wen[n];
                    if (bus.ramstate == ST_ACCESS) begin
                        wait_c[n] = 1'b0;
                        load_c    = bus.ramload;
                        state_d   = IDLE;
                        rr_d      = ~n;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        err_c[n] = 1'b1;
                        state_d  = IDLE;
                        rr_d     = ~n;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // While reset is held nothing is issued or reported; stall mirrors activity
    assign bus.req_wait = RST ? act : wait_c;
    assign bus.req_err  = RST ? 2'b00 : err_c;
    assign bus.req_load = RST ? '0 : load_c;
    assign bus.ramREN   = ~RST & ren_c;
    assign bus.ramWEN   = ~RST & wen_c;
    assign bus.ramaddr  = RST ? '0 : addr_c;
    assign bus.ramstore = RST ? '0 : store_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level ownership model
// compared against the outputs every cycle.
module tb_mem_arbiter;
    localparam int TMO = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_pass = 0;
    int   n_tot  = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Model: who owns the RAM, how long it has stalled, who has priority next
    int owner = -1;
    int age   = 0;
    int rr    = 0;

    always @(posedge CLK) begin : model_upd
        logic [1:0] a;
        a = bus.req_ren | bus.req_wen;
        if (RST) begin
            owner = -1; age = 0; rr = 0;
        end else if (owner < 0) begin
            if (a == 2'b11) begin owner = rr; age = 0; end
            else if (a != 2'b00) begin owner = a[1] ? 1 : 0; age = 0; end
        end else if (!a[owner]) begin
            owner = -1;
        end else if (bus.ramstate == 2'd2 || age == TMO) begin
            rr = 1 - owner;
            owner = -1;
        end else begin
            age++;
        end
    end

    always @(negedge CLK) begin : cmp
        logic [1:0]  a, ew, ee;
        logic        er, ewn;
        logic [31:0] ea, es, el;
        a = bus.req_ren | bus.req_wen;
        ew = a; ee = 2'b00; er = 1'b0; ewn = 1'b0; ea = '0; es = '0; el = '0;
        if (!RST && owner >= 0) begin
            ea = owner ? bus.req_addr1 : bus.req_addr0;
            es = owner ? bus.req_store1 : bus.req_store0;
            if (a[owner]) begin
                ewn = bus.req_wen[owner];
                er  = bus.req_ren[owner] && !ewn;
                if (bus.ramstate == 2'd2) begin
                    ew[owner] = 1'b0;
                    el = bus.ramload;
                end else if (age == TMO) begin
                    ee[owner] = 1'b1;
                end
            end
        end
        check("m_ramREN",   bus.ramREN,   er);
        check("m_ramWEN",   bus.ramWEN,   ewn);
        check("m_ramaddr",  bus.ramaddr,  ea);
        check("m_ramstore", bus.ramstore, es);
        check("m_req_load", bus.req_load, el);
        check("m_req_wait", bus.req_wait, ew);
        check("m_req_err",  bus.req_err,  ee);
    end

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        logic [31:0] glog[$];
        bus.req_ren = 2'b11; bus.req_wen = 2'b00;
        bus.req_addr0 = 32'h11; bus.req_addr1 = 32'h22;
        bus.req_store0 = 32'h33; bus.req_store1 = 32'h44;
        bus.ramload = 32'h55; bus.ramstate = 2'd2;
        cyc();
        cyc();
        #1;
        check("rst_wait", bus.req_wait, 2'b11);
        check("rst_ren",  bus.ramREN, 1'b0);
        check("rst_addr", bus.ramaddr, 32'h0);
        check("rst_load", bus.req_load, 32'h0);
        bus.req_ren = 2'b00;
        do_reset();

        // Single read, ACCESS two cycles after the grant
        bus.req_ren = 2'b01; bus.req_addr0 = 32'h40; bus.ramstate = 2'd0; bus.ramload = 32'h0;
        #1; check("rd_idle_ren", bus.ramREN, 1'b0);
        cyc(); bus.ramstate = 2'd1;
        #1; check("rd_gnt_ren", bus.ramREN, 1'b1); check("rd_gnt_addr", bus.ramaddr, 32'h40);
        check("rd_gnt_wait", bus.req_wait, 2'b01);
        cyc();
        cyc(); bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
        #1; check("rd_acc_wait", bus.req_wait, 2'b00); check("rd_acc_load", bus.req_load, 32'hDEADBEEF);
        cyc(); bus.req_ren = 2'b00; bus.ramstate = 2'd0; bus.ramload = 32'h0;
        #1; check("rd_after_ren", bus.ramREN, 1'b0);

        // Contention with one-cycle RAM
        cyc();
        bus.req_ren = 2'b11; bus.req_addr0 = 32'h100; bus.req_addr1 = 32'h200; bus.ramstate = 2'd2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.ramREN) glog.push_back(bus.ramaddr);
            cyc();
        end
        bus.req_ren = 2'b00;
        check("rr_count", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++)
            check("rr_order", glog[i], (i % 2 == 0) ? 32'h100 : 32'h200);
        cyc();

        // Read and write from the same requester: write wins
        bus.req_ren = 2'b10; bus.req_wen = 2'b10; bus.req_addr1 = 32'h80;
        bus.req_store1 = 32'h12345678; bus.ramstate = 2'd1;
        cyc();
        #1; check("rw_wen", bus.ramWEN, 1'b1); check("rw_ren", bus.ramREN, 1'b0);
        check("rw_store", bus.ramstore, 32'h12345678);
        bus.ramstate = 2'd2;
        #1; check("rw_done_wait", bus.req_wait, 2'b00);
        cyc(); bus.req_ren = 2'b00; bus.req_wen = 2'b00; bus.ramstate = 2'd0;
        cyc();

        // Timeout with requester 1 pending
        bus.req_ren = 2'b11; bus.ramstate = 2'd1; bus.req_addr0 = 32'h300; bus.req_addr1 = 32'h400;
        do_reset();
        cyc();
        for (int k = 0; k < 4; k++) begin
            #1; check("to_noerr", bus.req_err, 2'b00);
            cyc();
        end
        #1; check("to_err", bus.req_err, 2'b01); check("to_wait", bus.req_wait, 2'b11);
        cyc();
        #1; check("to_idle_ren", bus.ramREN, 1'b0); check("to_idle_err", bus.req_err, 2'b00);
        cyc();
        #1; check("to_next_addr", bus.ramaddr, 32'h400); check("to_next_ren", bus.ramREN, 1'b1);
        bus.req_ren = 2'b00; bus.ramstate = 2'd0;
        cyc();

        // Abort mid-grant
        bus.req_ren = 2'b01; bus.ramstate = 2'd1;
        cyc();
        #1; check("ab_gnt_ren", bus.ramREN, 1'b1);
        cyc(); bus.req_ren = 2'b00;
        #1; check("ab_ren", bus.ramREN, 1'b0); check("ab_err", bus.req_err, 2'b00);
        check("ab_wait", bus.req_wait, 2'b00);
        cyc();
        #1; check("ab_idle_ren", bus.ramREN, 1'b0);

        // Reset during GNT1 after rr has moved to 1
        bus.req_ren = 2'b01; bus.ramstate = 2'd2; bus.req_addr0 = 32'h500; bus.req_addr1 = 32'h600;
        cyc();
        cyc(); bus.req_ren = 2'b10; bus.ramstate = 2'd1;
        cyc();
        #1; check("rs_gnt1_addr", bus.ramaddr, 32'h600); check("rs_gnt1_ren", bus.ramREN, 1'b1);
        RST = 1'b1;
        cyc(); RST = 1'b0; bus.req_ren = 2'b11;
        #1; check("rs_ren", bus.ramREN, 1'b0); check("rs_wen", bus.ramWEN, 1'b0);
        cyc();
        #1; check("rs_rr0_addr", bus.ramaddr, 32'h500); check("rs_rr0_ren", bus.ramREN, 1'b1);
        bus.req_ren = 2'b00; bus.ramstate = 2'd0;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, RAM word address width in bits.
REQ-002 Parameter: DATA_W, default 32, RAM data word width in bits.
REQ-003 Parameter: TIMEOUT, default 255, maximum cycles one grant may stay in progress before it is forcibly released.
REQ-004 Port: CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 Port: RST  in  1  reset, synchronous, active-high.
REQ-006 Port: req_ren  in  2  per-requester read request, index 0/1.
REQ-007 Port: req_wen  in  2  per-requester write request.
REQ-008 Port: req_addr0, req_addr1  in  ADDR_W each  requester addresses.
REQ-009 Port: req_store0, req_store1  in  DATA_W each  requester write data.
REQ-010 Port: req_wait  out  2  per-requester stall; low means the transfer completes this cycle.
REQ-011 Port: req_load  out  DATA_W  read data, valid in the cycle the requester's req_wait is low.
REQ-012 Port: req_err  out  2  one-cycle timeout pulse per requester.
REQ-013 Port: ramREN, ramWEN  out  1 each  RAM read/write enables.
REQ-014 Port: ramaddr  out  ADDR_W  and ramstore  out  DATA_W  RAM address and write data.
REQ-015 Port: ramload  in  DATA_W  RAM read data.
REQ-016 Port: ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-017 A requester is active when req_ren[n] or req_wen[n] is high.
REQ-018 FSM states: IDLE, GNT0, GNT1; 2-bit state register; rr pointer (1 bit) names the requester that has priority next.
REQ-019 In IDLE, ram enables are low, and the next state depends on which requesters are active.
- Only n active: GNTn.
- Both active: GNT[rr].
- None active: stay in IDLE.
REQ-020 Arbitration latency: a request first seen in IDLE drives RAM on the following cycle; no RAM access is issued in the IDLE cycle itself.
REQ-021 In GNTn, ramaddr and ramstore follow req_addrn and req_storen combinationally.
REQ-022 In GNTn, ramWEN = req_wen[n].
REQ-023 In GNTn, ramREN = req_ren[n] & ~req_wen[n]; if both are high, the write wins and ramREN is 0.
REQ-024 In GNTn with ramstate==ACCESS, in the same cycle:
- req_wait[n]=0;
- req_load=ramload;
- next state IDLE;
- rr <= ~n.
REQ-025 In GNTn, ramstate FREE, BUSY or ERROR keeps the grant, keeps the enables asserted and holds req_wait[n]=1; ERROR is retried implicitly.
REQ-026 If requester n drops both enables while in GNTn: ram enables go low that cycle, next state IDLE, rr unchanged, no err.
REQ-027 req_wait[n] = active(n) & ~(state==GNTn & ramstate==ACCESS); req_wait[n]=0 when n is not active.
REQ-028 req_load = 0 whenever no completion occurs in that cycle.
REQ-029 Timeout counter (8 bits minimum, sized to hold TIMEOUT) clears on entry to GNTn and increments on each GNTn cycle without ACCESS.
REQ-030 When the timeout counter equals TIMEOUT and ramstate != ACCESS:
- req_err[n] pulses for 1 cycle;
- req_wait[n] stays 1;
- next state IDLE;
- rr <= ~n.
REQ-031 ACCESS in the same cycle as the timeout count completes normally, with no err.
REQ-032 A requester never receives two back-to-back grants while the other requester is waiting.
REQ-033 The non-granted requester's req_wait stays high for as long as it is active.

Reset
REQ-034 When RST is high at a rising CLK edge, the block enters IDLE, with rr=0 and the timeout counter=0.
REQ-035 Outputs during and after reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, req_load=0, req_err=0, req_wait=active mask.
REQ-036 Reset asserted mid-grant abandons the transfer: enables drop on the cycle after the reset edge, and no err and no completion are reported.

Verification
REQ-037 Single read: req_ren=01, addr0=0x40, RAM answers ACCESS 2 cycles after the grant with ramload=0xDEADBEEF -> ramREN high from cycle 1; req_wait[0]=0 and req_load=0xDEADBEEF in the ACCESS cycle; IDLE next.
REQ-038 Contention: req_ren=11 from reset, every RAM access takes 1 cycle -> grant order 0,1,0,1; rr toggles after each completion; neither requester is starved.
REQ-039 Read+write same requester: req_ren[1]=req_wen[1]=1, store1=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678.
REQ-040 Timeout: TIMEOUT=4, ramstate held BUSY -> req_err[0] pulses after 4 stalled grant cycles; state returns to IDLE; a pending requester 1 is granted next.
REQ-041 Abort and reset: requester 0 drops its request mid-grant -> IDLE, no err; separately, RST asserted in GNT1 -> ram enables are 0 on the next cycle, and rr=0.
